// File: rtl/v_registers_pipe_pkg.sv
// Shared defaults for the register pipeline and a clog2 helper
// used by instantiating code to size the occupancy counter.
package v_registers_pipe_pkg;

    localparam int          DEF_WIDTH   = 4;
    localparam int          DEF_DEPTH   = 3;
    localparam logic [3:0]  DEF_RST_VAL = 4'b0011;

    // Ceiling log2; clog2(DEPTH+1) gives the occupancy width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEF_CNT_W = clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/v_reg_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit.
// Ports: clk, rst (sync), clken, clr (valid clear), d/d_vld in, q/q_vld out.
module v_reg_stage
    import v_registers_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RST_VAL;
            q_vld <= 1'b0;
        end else begin
            // Data keeps shifting during a clear; only the valid is dropped.
            if (clken)
                q <= d;
            if (clr)
                q_vld <= 1'b0;
            else if (clken)
                q_vld <= d_vld;
        end
    end

endmodule

// File: rtl/v_registers_pipe.sv
// DEPTH-stage WIDTH-bit delay line with stall, flush, valid tracking
// and a registered occupancy count.
// Ports: clk, rst (sync, active-high), clken, flush, D/D_valid in;
//        Q/Q_valid (last stage), taps/taps_vld (all stages), occupancy.
module v_registers_pipe
    import v_registers_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL),
    parameter int               CNT_W   = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clken,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       D,
    input  logic                   D_valid,
    output logic [WIDTH-1:0]       Q,
    output logic                   Q_valid,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic [DEPTH-1:0]       taps_vld,
    output logic [CNT_W-1:0]       occupancy
);

    // Index 0 is the pipe input; index i+1 is the output of stage i.
    logic [DEPTH:0][WIDTH-1:0] dat;
    logic [DEPTH:0]            vld;

    assign dat[0] = D;
    assign vld[0] = D_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        v_reg_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clken (clken),
            .clr   (flush),
            .d     (dat[i]),
            .d_vld (vld[i]),
            .q     (dat[i+1]),
            .q_vld (vld[i+1])
        );
    end

    assign Q        = dat[DEPTH];
    assign Q_valid  = vld[DEPTH];
    assign taps     = dat[DEPTH:1];
    assign taps_vld = vld[DEPTH:1];

    // Tracked incrementally rather than popcounted so the output
    // comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (clken) begin
            unique case ({D_valid, Q_valid})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_v_registers_pipe.sv
// Directed bench for v_registers_pipe: DEPTH=3 main instance plus
// a DEPTH=1 instance sharing the same stimulus.
module tb_v_registers_pipe;
    import v_registers_pipe_pkg::*;

    localparam int W  = 4;
    localparam int DP = 3;
    localparam int CW = clog2(DP + 1);
    localparam int CW1 = clog2(2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clken = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  D = '0;
    logic          D_valid = 1'b0;

    logic [W-1:0]    Q;
    logic            Q_valid;
    logic [W*DP-1:0] taps;
    logic [DP-1:0]   taps_vld;
    logic [CW-1:0]   occupancy;

    logic [W-1:0]   q1;
    logic           q1_valid;
    logic [W-1:0]   taps1;
    logic [0:0]     taps1_vld;
    logic [CW1-1:0] occ1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    v_registers_pipe #(
        .WIDTH(W), .DEPTH(DP), .RST_VAL(4'b0011), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .clken(clken), .flush(flush),
        .D(D), .D_valid(D_valid),
        .Q(Q), .Q_valid(Q_valid), .taps(taps),
        .taps_vld(taps_vld), .occupancy(occupancy)
    );

    v_registers_pipe #(
        .WIDTH(W), .DEPTH(1), .RST_VAL(4'b0011), .CNT_W(CW1)
    ) dut1 (
        .clk(clk), .rst(rst), .clken(clken), .flush(flush),
        .D(D), .D_valid(D_valid),
        .Q(q1), .Q_valid(q1_valid), .taps(taps1),
        .taps_vld(taps1_vld), .occupancy(occ1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clken = 1'b0; flush = 1'b0;
        step();
        step();
        checks++;
        if (Q !== 4'h3) begin
            failures++; $display("FAIL reset_q got=%h exp=3", Q);
        end
        checks++;
        if (Q_valid !== 1'b0) begin
            failures++; $display("FAIL reset_qv got=%b exp=0", Q_valid);
        end
        checks++;
        if (taps !== 12'h333) begin
            failures++; $display("FAIL reset_taps got=%h exp=333", taps);
        end
        checks++;
        if (taps_vld !== 3'b000 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL reset_vld_occ got=%b/%0d exp=000/0",
                     taps_vld, occupancy);
        end
        checks++;
        if (q1 !== 4'h3 || q1_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_d1 got=%h/%b exp=3/0", q1, q1_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [3:0] din  [7] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0};
        logic       dv   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] eq   [7] = '{4'h3, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
        logic       eqv  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] eocc [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        clken = 1'b1;
        for (int i = 0; i < 7; i++) begin
            D = din[i]; D_valid = dv[i];
            step();
            checks++;
            if (Q !== eq[i] || Q_valid !== eqv[i] || occupancy !== eocc[i]) begin
                failures++;
                $display("FAIL stream[%0d] got=%h/%b/%0d exp=%h/%b/%0d",
                         i, Q, Q_valid, occupancy, eq[i], eqv[i], eocc[i]);
            end
        end
    endtask

    task automatic test_stall();
        clken = 1'b1; D = 4'hA; D_valid = 1'b1;
        step();
        clken = 1'b0; D = 'x; D_valid = 1'bx;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (taps !== 12'h00A || taps_vld !== 3'b001 || occupancy !== 2'd1) begin
                failures++;
                $display("FAIL stall[%0d] got=%h/%b/%0d exp=00a/001/1",
                         i, taps, taps_vld, occupancy);
            end
        end
        clken = 1'b1; D = 4'h0; D_valid = 1'b0;
        step();
        checks++;
        if (taps !== 12'h0A0 || Q_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_resume got=%h/%b exp=0a0/0", taps, Q_valid);
        end
        step();
        checks++;
        if (Q !== 4'hA || Q_valid !== 1'b1 || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL stall_out got=%h/%b/%0d exp=a/1/1",
                     Q, Q_valid, occupancy);
        end
        step();
        checks++;
        if (occupancy !== 2'd0 || taps_vld !== 3'b000) begin
            failures++;
            $display("FAIL stall_drain got=%0d/%b exp=0/000",
                     occupancy, taps_vld);
        end
    endtask

    task automatic test_bubble();
        logic [3:0] din  [6] = '{4'h5, 4'h6, 4'h7, 4'h0, 4'h0, 4'h0};
        logic       dv   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] eq   [6] = '{4'h0, 4'h0, 4'h5, 4'h6, 4'h7, 4'h0};
        logic       eqv  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] eocc [6] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
        clken = 1'b1;
        for (int i = 0; i < 6; i++) begin
            D = din[i]; D_valid = dv[i];
            step();
            checks++;
            if (Q !== eq[i] || Q_valid !== eqv[i] || occupancy !== eocc[i]) begin
                failures++;
                $display("FAIL bubble[%0d] got=%h/%b/%0d exp=%h/%b/%0d",
                         i, Q, Q_valid, occupancy, eq[i], eqv[i], eocc[i]);
            end
        end
    endtask

    task automatic test_flush();
        clken = 1'b1; D_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            D = 4'(i);
            step();
        end
        checks++;
        if (taps !== 12'h123 || taps_vld !== 3'b111 || occupancy !== 2'd3) begin
            failures++;
            $display("FAIL flush_fill got=%h/%b/%0d exp=123/111/3",
                     taps, taps_vld, occupancy);
        end
        flush = 1'b1; D = 4'h9; D_valid = 1'b1;
        step();
        checks++;
        if (taps_vld !== 3'b000 || occupancy !== 2'd0 || Q_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got=%b/%0d/%b exp=000/0/0",
                     taps_vld, occupancy, Q_valid);
        end
        flush = 1'b0; D = 4'h0; D_valid = 1'b0;
        step();
        checks++;
        if (taps_vld !== 3'b000 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL flush_lost got=%b/%0d exp=000/0",
                     taps_vld, occupancy);
        end
    endtask

    task automatic test_rst_mid();
        clken = 1'b1; D_valid = 1'b1;
        D = 4'h4; step();
        D = 4'h5; step();
        checks++;
        if (occupancy !== 2'd2) begin
            failures++;
            $display("FAIL rstmid_pre got=%0d exp=2", occupancy);
        end
        rst = 1'b1; flush = 1'b1; D = 4'hF;
        step();
        checks++;
        if (Q !== 4'h3 || Q_valid !== 1'b0 || taps !== 12'h333 ||
            taps_vld !== 3'b000 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL rstmid got=%h/%b/%h/%b/%0d exp=3/0/333/000/0",
                     Q, Q_valid, taps, taps_vld, occupancy);
        end
        checks++;
        if (q1 !== 4'h3 || q1_valid !== 1'b0 || occ1 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_d1 got=%h/%b/%0d exp=3/0/0",
                     q1, q1_valid, occ1);
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    task automatic test_depth1();
        clken = 1'b1; D_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            D = 4'(i);
            step();
            checks++;
            if (q1 !== 4'(i) || q1_valid !== 1'b1 || occ1 !== 1'b1) begin
                failures++;
                $display("FAIL d1_stream[%0d] got=%h/%b/%0d exp=%h/1/1",
                         i, q1, q1_valid, occ1, 4'(i));
            end
        end
        clken = 1'b0; D = 4'hE; D_valid = 1'b0;
        step();
        checks++;
        if (q1 !== 4'h4 || q1_valid !== 1'b1 || occ1 !== 1'b1) begin
            failures++;
            $display("FAIL d1_hold got=%h/%b/%0d exp=4/1/1",
                     q1, q1_valid, occ1);
        end
        clken = 1'b1;
        step();
        checks++;
        if (q1 !== 4'hE || q1_valid !== 1'b0 || occ1 !== 1'b0) begin
            failures++;
            $display("FAIL d1_drain got=%h/%b/%0d exp=e/0/0",
                     q1, q1_valid, occ1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_flush();
        test_rst_mid();
        test_depth1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
